// File: rtl/video_timing_pkg.sv
// Shared constants, polarity codes and FSM encoding for the video timing generator.
// Defaults describe a 1080p60 raster.
package video_timing_pkg;

    localparam int DATA_WIDTH_DEFAULT = 16;
    localparam int CNT_W_DEFAULT      = 12;

    localparam int H_SYNC_1080P   = 44;
    localparam int H_BP_1080P     = 148;
    localparam int H_ACTIVE_1080P = 1920;
    localparam int H_FP_1080P     = 88;
    localparam int V_SYNC_1080P   = 5;
    localparam int V_BP_1080P     = 36;
    localparam int V_ACTIVE_1080P = 1080;
    localparam int V_FP_1080P     = 4;

    localparam logic POL_HIGH = 1'b1;
    localparam logic POL_LOW  = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    function automatic logic in_window(input logic [31:0] pos, input int unsigned lo,
                                       input int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video output bundle: pixel request/return to the upstream FIFO plus sync, DE and pixel out.
interface video_timing_gen_if import video_timing_pkg::*; #(
    parameter int pDATA_WIDTH = DATA_WIDTH_DEFAULT
);

    logic [pDATA_WIDTH-1:0] i_video_data;
    logic                   o_data_req;
    logic                   o_vsyn;
    logic                   o_hsyn;
    logic                   o_de;
    logic [pDATA_WIDTH-1:0] o_video_data;
    logic                   o_frame_start;

    modport master (
        input  i_video_data,
        output o_data_req, o_vsyn, o_hsyn, o_de, o_video_data, o_frame_start
    );

    modport slave (
        output i_video_data,
        input  o_data_req, o_vsyn, o_hsyn, o_de, o_video_data, o_frame_start
    );

endinterface

// File: rtl/video_timing_counter.sv
// Modulo-pTOTAL counter with enable, terminal-count flag and a pAHEAD-step look-ahead value.
module video_timing_counter #(
    parameter int pCNT_W = 12,
    parameter int pTOTAL = 2200,
    parameter int pAHEAD = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    output logic [pCNT_W-1:0] o_cnt,
    output logic              o_tc,
    output logic [pCNT_W-1:0] o_ahead
);

    localparam logic [pCNT_W:0]   lpTOTAL = (pCNT_W+1)'(pTOTAL);
    localparam logic [pCNT_W:0]   lpAHEAD = (pCNT_W+1)'(pAHEAD);
    localparam logic [pCNT_W-1:0] lpLAST  = pCNT_W'(pTOTAL - 1);
    localparam logic [pCNT_W-1:0] lpONE   = pCNT_W'(1);

    logic [pCNT_W-1:0] r_cnt;
    logic [pCNT_W:0]   w_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + lpONE;
        end
    end

    // One extra bit so the look-ahead sum cannot overflow before the modulo correction.
    assign w_sum   = {1'b0, r_cnt} + lpAHEAD;
    assign o_ahead = (w_sum >= lpTOTAL) ? pCNT_W'(w_sum - lpTOTAL) : pCNT_W'(w_sum);
    assign o_cnt   = r_cnt;
    assign o_tc    = (r_cnt == lpLAST);

endmodule

// File: rtl/video_timing_gen.sv
// Transmit-side video timing generator: registered sync/DE/pixel outputs with a
// two-cycle look-ahead FIFO read request; a stop request always finishes the frame.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   pDATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int   pCNT_W      = CNT_W_DEFAULT,
    parameter int   pH_SYNC     = H_SYNC_1080P,
    parameter int   pH_BP       = H_BP_1080P,
    parameter int   pH_ACTIVE   = H_ACTIVE_1080P,
    parameter int   pH_FP       = H_FP_1080P,
    parameter int   pV_SYNC     = V_SYNC_1080P,
    parameter int   pV_BP       = V_BP_1080P,
    parameter int   pV_ACTIVE   = V_ACTIVE_1080P,
    parameter int   pV_FP       = V_FP_1080P,
    parameter logic pHS_POL     = POL_HIGH,
    parameter logic pVS_POL     = POL_HIGH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    output logic               o_busy,
    video_timing_gen_if.master vif
);

    localparam int lpH_TOTAL    = pH_SYNC + pH_BP + pH_ACTIVE + pH_FP;
    localparam int lpV_TOTAL    = pV_SYNC + pV_BP + pV_ACTIVE + pV_FP;
    localparam int lpH_DE_START = pH_SYNC + pH_BP;
    localparam int lpV_DE_START = pV_SYNC + pV_BP;
    localparam logic [pCNT_W-1:0] lpH_AHEAD = pCNT_W'(2);

    state_t r_state;
    state_t w_next;

    logic [pCNT_W-1:0] w_h, w_v, w_h_ahead, w_v_next, w_v_ahead;
    logic w_h_tc, w_v_tc, w_run, w_last, w_h_wrap, w_frame_wrap;
    logic w_hs, w_vs, w_de, w_de_ahead, w_req;

    logic                   r_hsyn, r_vsyn, r_de, r_req, r_frame_start;
    logic [pDATA_WIDTH-1:0] r_video_data;

    assign w_run  = (r_state != IDLE);
    assign w_last = w_h_tc & w_v_tc;

    video_timing_counter #(.pCNT_W(pCNT_W), .pTOTAL(lpH_TOTAL), .pAHEAD(2)) u_h_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_run),
        .o_cnt  (w_h),
        .o_tc   (w_h_tc),
        .o_ahead(w_h_ahead)
    );

    video_timing_counter #(.pCNT_W(pCNT_W), .pTOTAL(lpV_TOTAL), .pAHEAD(1)) u_v_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (w_run & w_h_tc),
        .o_cnt  (w_v),
        .o_tc   (w_v_tc),
        .o_ahead(w_v_next)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // A stop request only takes effect at the last position of the frame.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (i_en) w_next = RUN;
            RUN:     if (!i_en) w_next = w_last ? IDLE : STOP;
            STOP:    if (i_en) w_next = RUN;
                     else if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_hs = in_window(32'(w_h), 0, pH_SYNC);
    assign w_vs = in_window(32'(w_v), 0, pV_SYNC);
    assign w_de = in_window(32'(w_h), lpH_DE_START, pH_ACTIVE)
                & in_window(32'(w_v), lpV_DE_START, pV_ACTIVE);

    // The request is DE two positions ahead; across a frame boundary it is only
    // issued while running will continue, so a stopping frame never over-reads.
    assign w_h_wrap     = (w_h_ahead < lpH_AHEAD);
    assign w_v_ahead    = w_h_wrap ? w_v_next : w_v;
    assign w_frame_wrap = w_h_wrap & w_v_tc;
    assign w_de_ahead   = in_window(32'(w_h_ahead), lpH_DE_START, pH_ACTIVE)
                        & in_window(32'(w_v_ahead), lpV_DE_START, pV_ACTIVE);
    assign w_req        = w_run & w_de_ahead & (~w_frame_wrap | i_en);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hsyn        <= ~pHS_POL;
            r_vsyn        <= ~pVS_POL;
            r_de          <= 1'b0;
            r_req         <= 1'b0;
            r_frame_start <= 1'b0;
            r_video_data  <= '0;
        end else begin
            r_hsyn        <= (w_run & w_hs) ? pHS_POL : ~pHS_POL;
            r_vsyn        <= (w_run & w_vs) ? pVS_POL : ~pVS_POL;
            r_de          <= w_run & w_de;
            r_req         <= w_req;
            r_frame_start <= w_run & (w_h == '0) & (w_v == '0);
            r_video_data  <= (w_run & w_de) ? vif.i_video_data : '0;
        end
    end

    assign vif.o_hsyn        = r_hsyn;
    assign vif.o_vsyn        = r_vsyn;
    assign vif.o_de          = r_de;
    assign vif.o_data_req    = r_req;
    assign vif.o_frame_start = r_frame_start;
    assign vif.o_video_data  = r_video_data;
    assign o_busy            = w_run;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a 15x8 raster (H 3/2/8/2, V 2/1/4/1, hsync
// active-low) with a latency-1 FIFO model that returns an incrementing count.
module tb_video_timing_gen;

    localparam int H_TOTAL = 15;
    localparam int F_TOTAL = 120;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic req;
        logic busy;
    } expRec_t;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic busy;

    int checks  = 0;
    int errors  = 0;
    int expPix  = 0;
    int reqSeen = 0;

    expRec_t     recQ[$];
    logic [15:0] pixQ[$];

    video_timing_gen_if #(.pDATA_WIDTH(16)) vif();

    video_timing_gen #(
        .pDATA_WIDTH(16), .pCNT_W(12),
        .pH_SYNC(3), .pH_BP(2), .pH_ACTIVE(8), .pH_FP(2),
        .pV_SYNC(2), .pV_BP(1), .pV_ACTIVE(4), .pV_FP(1),
        .pHS_POL(1'b0), .pVS_POL(1'b1)
    ) dut (
        .i_clk (clock),
        .i_rst (reset),
        .i_en  (enable),
        .o_busy(busy),
        .vif   (vif)
    );

    always #5 clock = ~clock;

    function automatic logic deAt(input int h, input int v);
        return (h >= 5) && (h < 13) && (v >= 3) && (v < 7);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic enVal);
        @(posedge clock);
        #1;
        reset  = rstVal;
        enable = enVal;
    endtask

    task automatic pushIdle(input logic busyExp);
        expRec_t r;
        r = '{hs: 1'b1, vs: 1'b0, de: 1'b0, fs: 1'b0, req: 1'b0, busy: busyExp};
        recQ.push_back(r);
    endtask

    // k counts output positions from the first frame start, running across frames.
    task automatic pushPos(input int k, input logic busyExp);
        expRec_t r;
        int p, pa;
        p  = k % F_TOTAL;
        pa = (k + 2) % F_TOTAL;
        r.hs   = ((p % H_TOTAL) < 3) ? 1'b0 : 1'b1;
        r.vs   = ((p / H_TOTAL) < 2) ? 1'b1 : 1'b0;
        r.de   = deAt(p % H_TOTAL, p / H_TOTAL);
        r.fs   = (p == 0);
        r.req  = deAt(pa % H_TOTAL, pa / H_TOTAL);
        r.busy = busyExp;
        recQ.push_back(r);
        if (r.de) begin
            pixQ.push_back(16'(expPix));
            expPix++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_hsyn"},  32'(vif.o_hsyn),        32'd1);
        checkOutput({tag, "_vsyn"},  32'(vif.o_vsyn),        32'd0);
        checkOutput({tag, "_de"},    32'(vif.o_de),          32'd0);
        checkOutput({tag, "_req"},   32'(vif.o_data_req),    32'd0);
        checkOutput({tag, "_data"},  32'(vif.o_video_data),  32'd0);
        checkOutput({tag, "_fs"},    32'(vif.o_frame_start), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy),              32'd0);
    endtask

    initial begin : fifoModel
        int   count;
        logic pending;
        count   = 0;
        pending = 1'b0;
        vif.i_video_data = 16'hBEEF;
        forever begin
            @(negedge clock);
            if (reset) begin
                count   = 0;
                pending = 1'b0;
                vif.i_video_data = 16'hBEEF;
            end else begin
                if (pending) begin
                    vif.i_video_data = 16'(count);
                    count++;
                end else begin
                    vif.i_video_data = 16'hBEEF;
                end
                pending = vif.o_data_req;
            end
        end
    end

    initial begin : monitor
        expRec_t     r;
        logic [15:0] px;
        forever begin
            @(negedge clock);
            if (recQ.size() != 0) begin
                r = recQ.pop_front();
                checkOutput("hsyn",        32'(vif.o_hsyn),        32'(r.hs));
                checkOutput("vsyn",        32'(vif.o_vsyn),        32'(r.vs));
                checkOutput("de",          32'(vif.o_de),          32'(r.de));
                checkOutput("frame_start", 32'(vif.o_frame_start), 32'(r.fs));
                checkOutput("data_req",    32'(vif.o_data_req),    32'(r.req));
                checkOutput("busy",        32'(busy),              32'(r.busy));
                if (vif.o_data_req === 1'b1) reqSeen++;
                if (r.de) begin
                    if (pixQ.size() != 0) begin
                        px = pixQ.pop_front();
                        checkOutput("pixel", 32'(vif.o_video_data), 32'(px));
                    end else begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL pixel_queue: got %0h with no expected pixel left",
                                 vif.o_video_data);
                    end
                end else begin
                    checkOutput("blank_data", 32'(vif.o_video_data), 32'd0);
                end
            end
        end
    end

    initial begin : stimulus
        logic en;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0);
        checkResetValues("reset_hold");

        // Three frames: a 10-cycle enable dropout in frame 2, then stop at h=5,v=4 of frame 3.
        applyStimulus(1'b0, 1'b1);
        pushIdle(1'b0);
        pushIdle(1'b1);
        for (int k = 0; k < 359; k++) pushPos(k, 1'b1);
        pushPos(359, 1'b0);
        repeat (5) pushIdle(1'b0);
        for (int c = 1; c < 367; c++) begin
            en = !((c >= 150 && c < 160) || c >= 306);
            applyStimulus(1'b0, en);
        end

        // Restart, then hit reset at h=10,v=4 while DE is active.
        applyStimulus(1'b0, 1'b1);
        pushIdle(1'b0);
        pushIdle(1'b1);
        for (int k = 0; k < 69; k++) pushPos(k, 1'b1);
        for (int c = 1; c < 71; c++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (3) pushIdle(1'b0);
        #1;
        checkResetValues("reset_async");
        repeat (2) applyStimulus(1'b1, 1'b1);

        applyStimulus(1'b0, 1'b1);
        expPix = 0;
        pushIdle(1'b0);
        pushIdle(1'b1);
        for (int k = 0; k < 120; k++) pushPos(k, 1'b1);
        for (int c = 1; c < 122; c++) applyStimulus(1'b0, 1'b1);

        for (int i = 0; i < 50 && recQ.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        checkOutput("records_left", 32'(recQ.size()), 32'd0);
        checkOutput("pixels_left",  32'(pixQ.size()), 32'd0);
        checkOutput("req_total",    32'(reqSeen),     32'd142);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
